// File: rtl/jac_to_affine.sv
// Jacobian-to-affine point conversion: x = X*Z^-2, y = Y*Z^-3 mod M, using an external inverter.
// Optional point-at-infinity short-cut enabled by defining JAC_TO_AFFINE_INF_CHECK_EN.
module jac_to_affine #(
  parameter int unsigned DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] opX,
  input  logic [DATA_WIDTH-1:0] opY,
  input  logic [DATA_WIDTH-1:0] opZ,
  input  logic [DATA_WIDTH-1:0] opM,
  output logic                  inv_in_valid,
  output logic [DATA_WIDTH-1:0] inv_opA,
  output logic [DATA_WIDTH-1:0] inv_opM,
  input  logic                  inv_out_valid,
  input  logic [DATA_WIDTH-1:0] inv_out_data,
  output logic [DATA_WIDTH-1:0] out_x,
  output logic [DATA_WIDTH-1:0] out_y,
  output logic                  out_inf,
  output logic                  out_valid,
  output logic                  busy
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned BitW = $clog2(DATA_WIDTH);
  localparam logic [BitW-1:0] BitMax = BitW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StInvReq, StInvWait, StMul, StDone} state_e;

  state_e state_q, state_d;
  logic [W-1:0]    x_q, x_d, y_q, y_d, z_q, z_d, m_q, m_d;
  logic [W-1:0]    zi_q, zi_d, zi2_q, zi2_d, zi3_q, zi3_d, xr_q, xr_d;
  logic [W-1:0]    out_x_q, out_x_d, out_y_q, out_y_d;
  logic [W+1:0]    acc_q, acc_d;
  logic [BitW-1:0] bit_q, bit_d;
  logic [1:0]      phase_q, phase_d;
`ifdef JAC_TO_AFFINE_INF_CHECK_EN
  logic            out_inf_q, out_inf_d;
`endif

  logic [W-1:0] mul_a, mul_b;
  logic [W+1:0] m_ext, acc_sh, acc_dbl, acc_add, acc_new;
  logic [W-1:0] prod;

  // Operand routing for the four products: Zi*Zi, X*Zi2, Zi2*Zi, Y*Zi3.
  always_comb begin
    mul_a = zi_q;
    mul_b = zi_q;
    unique case (phase_q)
      2'd0: begin mul_a = zi_q;  mul_b = zi_q;  end
      2'd1: begin mul_a = x_q;   mul_b = zi2_q; end
      2'd2: begin mul_a = zi2_q; mul_b = zi_q;  end
      2'd3: begin mul_a = y_q;   mul_b = zi3_q; end
      default: ;
    endcase
  end

  // One MSB-first interleaved step; acc < M so each reduction needs one subtraction.
  always_comb begin
    m_ext   = {2'b00, m_q};
    acc_sh  = acc_q << 1;
    acc_dbl = (acc_sh >= m_ext) ? (acc_sh - m_ext) : acc_sh;
    acc_add = acc_dbl + {2'b00, mul_a};
    if (mul_b[bit_q]) begin
      acc_new = (acc_add >= m_ext) ? (acc_add - m_ext) : acc_add;
    end else begin
      acc_new = acc_dbl;
    end
    prod = acc_new[W-1:0];
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    m_d     = m_q;
    zi_d    = zi_q;
    zi2_d   = zi2_q;
    zi3_d   = zi3_q;
    xr_d    = xr_q;
    out_x_d = out_x_q;
    out_y_d = out_y_q;
    acc_d   = acc_q;
    bit_d   = bit_q;
    phase_d = phase_q;
`ifdef JAC_TO_AFFINE_INF_CHECK_EN
    out_inf_d = out_inf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d     = opX;
          y_d     = opY;
          z_d     = opZ;
          m_d     = opM;
          state_d = StLoad;
        end
      end
      StLoad: begin
        state_d = StInvReq;
`ifdef JAC_TO_AFFINE_INF_CHECK_EN
        if (z_q == '0) begin
          out_x_d   = '0;
          out_y_d   = '0;
          out_inf_d = 1'b1;
          state_d   = StDone;
        end
`endif
      end
      StInvReq: state_d = StInvWait;
      StInvWait: begin
        if (inv_out_valid) begin
          zi_d    = inv_out_data;
          acc_d   = '0;
          bit_d   = BitMax;
          phase_d = 2'd0;
          state_d = StMul;
        end
      end
      StMul: begin
        acc_d = acc_new;
        if (bit_q == '0) begin
          acc_d   = '0;
          bit_d   = BitMax;
          phase_d = phase_q + 2'd1;
          unique case (phase_q)
            2'd0: zi2_d = prod;
            2'd1: xr_d  = prod;
            2'd2: zi3_d = prod;
            2'd3: begin
              out_x_d = xr_q;
              out_y_d = prod;
`ifdef JAC_TO_AFFINE_INF_CHECK_EN
              out_inf_d = 1'b0;
`endif
              state_d = StDone;
            end
            default: ;
          endcase
        end else begin
          bit_d = bit_q - 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      m_q       <= '0;
      zi_q      <= '0;
      zi2_q     <= '0;
      zi3_q     <= '0;
      xr_q      <= '0;
      out_x_q   <= '0;
      out_y_q   <= '0;
      acc_q     <= '0;
      bit_q     <= '0;
      phase_q   <= '0;
`ifdef JAC_TO_AFFINE_INF_CHECK_EN
      out_inf_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      m_q       <= m_d;
      zi_q      <= zi_d;
      zi2_q     <= zi2_d;
      zi3_q     <= zi3_d;
      xr_q      <= xr_d;
      out_x_q   <= out_x_d;
      out_y_q   <= out_y_d;
      acc_q     <= acc_d;
      bit_q     <= bit_d;
      phase_q   <= phase_d;
`ifdef JAC_TO_AFFINE_INF_CHECK_EN
      out_inf_q <= out_inf_d;
`endif
    end
  end

  assign inv_in_valid = (state_q == StInvReq);
  assign inv_opA      = z_q;
  assign inv_opM      = m_q;
  assign out_x        = out_x_q;
  assign out_y        = out_y_q;
  assign out_valid    = (state_q == StDone);
  assign busy         = (state_q != StIdle);
`ifdef JAC_TO_AFFINE_INF_CHECK_EN
  assign out_inf      = out_inf_q;
`else
  assign out_inf      = 1'b0;
`endif

endmodule
